// File: rtl/serial_full_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial subtractor.
// The master side requests work; the slave side is the subtractor itself.
interface serial_full_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_full_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
// The result registers update only when an operation completes.
module serial_full_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    serial_full_subtractor_if.slave   bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_b_q, sh_d_q, diff_q;
    logic [WIDTH-1:0] sh_d_next;
    logic             brw_q, borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             x, y, d, bnew;
    logic             accept, last;
    logic             busy, done;

    // 1-bit full subtractor on the current LSBs.
    assign x    = sh_a_q[0];
    assign y    = sh_b_q[0];
    assign d    = x ^ y ^ brw_q;
    assign bnew = (~x & y) | (~(x ^ y) & brw_q);

    assign accept = bus.start && ((state_q == StIdle) || (state_q == StDone));
    assign last   = (cnt_q == CW'(WIDTH - 1));

    if (WIDTH == 1) begin : g_w1
        assign sh_d_next = d;
    end else begin : g_wn
        assign sh_d_next = {d, sh_d_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = bus.start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sh_d_q   <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            sh_a_q <= bus.a;
            sh_b_q <= bus.b;
            brw_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (state_q == StRun) begin
            sh_a_q <= sh_a_q >> 1;
            sh_b_q <= sh_b_q >> 1;
            sh_d_q <= sh_d_next;
            brw_q  <= bnew;
            cnt_q  <= cnt_q + CW'(1);
            if (last) begin
                diff_q   <= sh_d_next;
                borrow_q <= bnew;
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_full_subtractor.sv
// Randomized self-checking bench for serial_full_subtractor (WIDTH=8 and WIDTH=1 instances)
// against an arithmetic reference: {borrow_out, diff} = {0,a} - {0,b}, result after WIDTH+1 edges.
module tb_serial_full_subtractor;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_full_subtractor_if #(.WIDTH(8)) if8 ();
    serial_full_subtractor_if #(.WIDTH(1)) if1 ();

    serial_full_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_full_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    int n_checks = 0;
    int n_errors = 0;

    // Last completed result of the 8-bit instance, as the outputs must hold it.
    logic [7:0] m_diff;
    logic       m_brw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic busy_e, input logic done_e);
        check({tag, ".busy"}, 32'(if8.busy), 32'(busy_e));
        check({tag, ".done"}, 32'(if8.done), 32'(done_e));
        check({tag, ".diff"}, 32'(if8.diff), 32'(m_diff));
        check({tag, ".borrow"}, 32'(if8.borrow_out), 32'(m_brw));
    endtask

    task automatic idle8(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check8("idle", 1'b0, 1'b0);
        end
    endtask

    // Called with the accepting edge still ahead; returns sampled just after the done edge.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit hold);
        logic [8:0] r;
        r = {1'b0, a} - {1'b0, b};
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (hold) begin
                if8.a = 8'($urandom);
                if8.b = 8'($urandom);
            end else begin
                if8.start = 1'b0;
            end
            check8("run", 1'b1, 1'b0);
            tick();
        end
        if8.start = 1'b0;
        m_diff = r[7:0];
        m_brw  = r[8];
        check8("done", 1'b0, 1'b1);
    endtask

    task automatic op1(input logic a, input logic b);
        logic [1:0] r;
        r = {1'b0, a} - {1'b0, b};
        if1.start = 1'b1;
        if1.a     = a;
        if1.b     = b;
        tick();
        if1.start = 1'b0;
        check("w1.run.busy", 32'(if1.busy), 32'd1);
        check("w1.run.done", 32'(if1.done), 32'd0);
        tick();
        check("w1.done.done", 32'(if1.done), 32'd1);
        check("w1.done.busy", 32'(if1.busy), 32'd0);
        check("w1.result", 32'({if1.borrow_out, if1.diff}), 32'(r));
        tick();
        check("w1.after.done", 32'(if1.done), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        if8.start = 1'b0;
        if8.a     = '0;
        if8.b     = '0;
        if1.start = 1'b0;
        if1.a     = '0;
        if1.b     = '0;
        m_diff    = '0;
        m_brw     = 1'b0;
        tick();
        tick();
        check8("reset", 1'b0, 1'b0);
        check("w1.reset.busy", 32'(if1.busy), 32'd0);
        check("w1.reset.done", 32'(if1.done), 32'd0);
        check("w1.reset.result", 32'({if1.borrow_out, if1.diff}), 32'd0);
        rst = 1'b0;
        idle8(1);

        // Directed cases: basic, underflow, equal operands.
        op8(8'h5A, 8'h3C, 1'b0);
        idle8(2);
        op8(8'h00, 8'h01, 1'b0);
        idle8(1);
        op8(8'hFF, 8'hFF, 1'b0);
        idle8(1);

        // start held with changing operands during RUN must be ignored.
        op8(8'hC3, 8'h17, 1'b1);
        idle8(2);

        // Back-to-back: second start lands in the DONE cycle.
        op8(8'h77, 8'h22, 1'b0);
        op8(8'h10, 8'h20, 1'b0);
        idle8(1);

        // Reset in the fourth RUN cycle aborts without a done pulse.
        if8.start = 1'b1;
        if8.a     = 8'hE1;
        if8.b     = 8'h0F;
        tick();
        if8.start = 1'b0;
        repeat (3) tick();
        check8("pre_abort", 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        m_diff = '0;
        m_brw  = 1'b0;
        check8("abort", 1'b0, 1'b0);
        idle8(10);
        op8(8'h42, 8'h99, 1'b0);
        idle8(1);

        // WIDTH=1 exhaustive.
        for (int i = 0; i < 4; i++) begin
            op1(1'(i >> 1), 1'(i));
        end

        // Random regression with random gaps; gap 0 chains into the DONE cycle.
        for (int i = 0; i < 40; i++) begin
            op8(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
            idle8(int'($urandom_range(0, 2)));
        end
        idle8(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
